// File: rtl/fifo_pkg.sv
// Shared definitions for the single-clock FIFO: default sizes and the
// data/pointer types used by the buffer and its storage.
package fifo_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int ADDR_WIDTH = 3;
  localparam int DEPTH      = 1 << ADDR_WIDTH;

  // One word of FIFO payload.
  typedef logic [DATA_WIDTH-1:0] data_t;

  // Pointer = address bits plus one wrap bit in the MSB.
  typedef logic [ADDR_WIDTH:0] ptr_t;

endpackage : fifo_pkg

// File: rtl/fifo_mem.sv
// Storage for the FIFO: a DEPTH x DATA_WIDTH register array with one
// write port and one registered read port whose output clears on reset.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = fifo_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = fifo_pkg::ADDR_WIDTH,
  parameter int DEPTH      = fifo_pkg::DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Store the incoming word; contents are deliberately left untouched by reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Registered read: rdata only changes on an accepted read, otherwise holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule : fifo_mem

// File: rtl/async_fifo_top.sv
// Single-clock FIFO top: owns the wrap-bit pointers, qualifies the
// write/read requests against the current flags and registers full/empty
// from the next-state pointers so the flags track the pointers exactly.
module async_fifo_top
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = fifo_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = fifo_pkg::ADDR_WIDTH,
  parameter int DEPTH      = fifo_pkg::DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  w_en,
  input  logic [DATA_WIDTH-1:0] D_in,
  input  logic                  r_en,
  output logic [DATA_WIDTH-1:0] D_out,
  output logic                  full,
  output logic                  empty
);

  logic [ADDR_WIDTH:0] wr_ptr;
  logic [ADDR_WIDTH:0] rd_ptr;
  logic [ADDR_WIDTH:0] wr_ptr_nxt;
  logic [ADDR_WIDTH:0] rd_ptr_nxt;
  logic                w_acc;
  logic                r_acc;

  // Accept each request against the current flags, then derive next pointers.
  always_comb begin
    w_acc      = w_en && !full;
    r_acc      = r_en && !empty;
    wr_ptr_nxt = wr_ptr;
    rd_ptr_nxt = rd_ptr;
    if (w_acc) begin
      wr_ptr_nxt = wr_ptr + 1'b1;
    end
    if (r_acc) begin
      rd_ptr_nxt = rd_ptr + 1'b1;
    end
  end

  // Advance pointers and register flags computed from the next-state pointers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      empty  <= 1'b1;
      full   <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr_nxt;
      rd_ptr <= rd_ptr_nxt;
      empty  <= (wr_ptr_nxt == rd_ptr_nxt);
      full   <= (wr_ptr_nxt[ADDR_WIDTH-1:0] == rd_ptr_nxt[ADDR_WIDTH-1:0]) &&
                (wr_ptr_nxt[ADDR_WIDTH] != rd_ptr_nxt[ADDR_WIDTH]);
    end
  end

  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (w_acc),
    .waddr (wr_ptr[ADDR_WIDTH-1:0]),
    .wdata (D_in),
    .re    (r_acc),
    .raddr (rd_ptr[ADDR_WIDTH-1:0]),
    .rdata (D_out)
  );

endmodule : async_fifo_top

// File: tb/tb_async_fifo_top.sv
// Testbench for async_fifo_top: a queue-based occupancy model checked
// against the DUT every cycle, plus directed vectors with literal values.
module tb_async_fifo_top;

  localparam int DW    = 16;
  localparam int DEPTH = 8;

  logic          clk;
  logic          rst;
  logic          w_en;
  logic [DW-1:0] D_in;
  logic          r_en;
  logic [DW-1:0] D_out;
  logic          full;
  logic          empty;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [DW-1:0] model_q [$];
  logic [DW-1:0] model_dout;
  bit            model_valid = 0;

  async_fifo_top dut (
    .clk   (clk),
    .rst   (rst),
    .w_en  (w_en),
    .D_in  (D_in),
    .r_en  (r_en),
    .D_out (D_out),
    .full  (full),
    .empty (empty)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: a plain queue, requests judged on occupancy before the edge.
  always @(posedge clk) begin
    bit do_rd;
    bit do_wr;
    if (rst) begin
      model_q.delete();
      model_dout = '0;
    end else begin
      do_rd = r_en && (model_q.size() > 0);
      do_wr = w_en && (model_q.size() < DEPTH);
      if (do_rd) model_dout = model_q.pop_front();
      if (do_wr) model_q.push_back(D_in);
    end
    model_valid = 1'b1;
  end

  // Every-cycle comparison of the DUT against the model, away from the active edge.
  always @(negedge clk) begin
    if (model_valid) begin
      tests_run++;
      if (D_out !== model_dout || empty !== (model_q.size() == 0) ||
          full !== (model_q.size() == DEPTH)) begin
        tests_failed++;
        $display("[TB] FAIL model_cmp t=%0t: D_out=%0d empty=%0b full=%0b, required D_out=%0d empty=%0b full=%0b",
                 $time, D_out, empty, full, model_dout,
                 (model_q.size() == 0), (model_q.size() == DEPTH));
      end
    end
  end

  // Drive one cycle of inputs and return on the following falling edge.
  task automatic applyStimulus(input logic rst_v, input logic w_v,
                               input logic [DW-1:0] d_v, input logic r_v);
    rst  = rst_v;
    w_en = w_v;
    D_in = d_v;
    r_en = r_v;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Compare one DUT value against a hand-computed literal.
  task automatic checkOutput(input string name, input logic [DW-1:0] actual,
                             input logic [DW-1:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, required %0d", name, actual, expected);
    end
  endtask

  // Directed sequences with literal expectations.
  initial begin
    rst  = 1'b1;
    w_en = 1'b0;
    r_en = 1'b0;
    D_in = '0;
    @(negedge clk);

    // Reset held for two cycles, then a read on the empty FIFO.
    applyStimulus(1, 0, 0, 0);
    applyStimulus(1, 0, 0, 0);
    checkOutput("reset_empty", {15'd0, empty}, 16'd1);
    checkOutput("reset_full",  {15'd0, full},  16'd0);
    checkOutput("reset_dout",  D_out,          16'd0);
    applyStimulus(0, 0, 0, 1);
    checkOutput("underflow_dout",  D_out,          16'd0);
    checkOutput("underflow_empty", {15'd0, empty}, 16'd1);

    // Basic ordering: 5..9 stored, 10..12 presented without w_en.
    for (int v = 5; v <= 9; v++) applyStimulus(0, 1, DW'(v), 0);
    checkOutput("basic_not_empty", {15'd0, empty}, 16'd0);
    for (int v = 10; v <= 12; v++) applyStimulus(0, 0, DW'(v), 0);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(0, 0, 0, 1);
      checkOutput("basic_read", D_out, (i < 5) ? DW'(5 + i) : 16'd9);
      if (i == 4) checkOutput("basic_empty", {15'd0, empty}, 16'd1);
    end

    // Fill to full, attempt overflow, then drain.
    for (int v = 1; v <= 8; v++) begin
      applyStimulus(0, 1, DW'(v), 0);
      if (v == 7) checkOutput("fill_not_full", {15'd0, full}, 16'd0);
    end
    checkOutput("fill_full", {15'd0, full}, 16'd1);
    applyStimulus(0, 1, 16'd99, 0);
    checkOutput("overflow_full", {15'd0, full}, 16'd1);
    for (int v = 1; v <= 8; v++) begin
      applyStimulus(0, 0, 0, 1);
      checkOutput("drain_read", D_out, DW'(v));
      if (v == 1) checkOutput("drain_full_clear", {15'd0, full}, 16'd0);
    end
    checkOutput("drain_empty", {15'd0, empty}, 16'd1);

    // Simultaneous access on a partly filled FIFO.
    for (int v = 1; v <= 3; v++) applyStimulus(0, 1, DW'(v), 0);
    applyStimulus(0, 1, 16'd4, 1);
    checkOutput("simul_dout", D_out, 16'd1);
    for (int v = 2; v <= 4; v++) begin
      applyStimulus(0, 0, 0, 1);
      checkOutput("simul_drain", D_out, DW'(v));
    end
    checkOutput("simul_occupancy3", {15'd0, empty}, 16'd1);

    // Simultaneous access when full: read wins, write dropped.
    for (int v = 50; v <= 57; v++) applyStimulus(0, 1, DW'(v), 0);
    applyStimulus(0, 1, 16'd77, 1);
    checkOutput("full_simul_dout", D_out,         16'd50);
    checkOutput("full_simul_full", {15'd0, full}, 16'd0);
    for (int v = 51; v <= 57; v++) begin
      applyStimulus(0, 0, 0, 1);
      checkOutput("full_simul_drain", D_out, DW'(v));
    end
    checkOutput("full_simul_empty", {15'd0, empty}, 16'd1);

    // Simultaneous access when empty: write accepted, read dropped.
    applyStimulus(0, 1, 16'd33, 1);
    checkOutput("empty_simul_hold",  D_out,          16'd57);
    checkOutput("empty_simul_empty", {15'd0, empty}, 16'd0);
    applyStimulus(0, 0, 0, 1);
    checkOutput("empty_simul_read", D_out, 16'd33);

    // Wrap-around over many write/read pairs.
    for (int v = 100; v <= 119; v++) begin
      applyStimulus(0, 1, DW'(v), 0);
      applyStimulus(0, 0, 0, 1);
      checkOutput("wrap_read", D_out, DW'(v));
    end
    checkOutput("wrap_empty", {15'd0, empty}, 16'd1);

    // Reset mid-operation, with a write request in the reset cycle.
    for (int v = 7; v <= 9; v++) applyStimulus(0, 1, DW'(v), 0);
    applyStimulus(1, 1, 16'd55, 1);
    checkOutput("midrst_empty", {15'd0, empty}, 16'd1);
    checkOutput("midrst_dout",  D_out,          16'd0);
    applyStimulus(0, 1, 16'd42, 0);
    applyStimulus(0, 0, 0, 1);
    checkOutput("midrst_read",  D_out,          16'd42);
    checkOutput("midrst_final", {15'd0, empty}, 16'd1);

    applyStimulus(0, 0, 0, 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_async_fifo_top
